masked_match_detector: RTL and testbench

- Clocked, parametrised successor to the two-bit "f = 1 when x == 11" decoder.
- Compares a W-bit input sample x against a programmable pattern under a programmable mask, and drives a registered flag f.
- Three modes: level decode, run-length qualification (N consecutive matches), and one-shot detection with re-arm.
- Sits between an input sampler and control logic that needs qualified, glitch-free match events plus a saturating hit count.

---
 rtl/masked_match_detector.sv | 133 +++++++++++++
 tb/tb_masked_match_detector.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_match_detector.sv
// ============================================================================
// Module   : masked_match_detector
// Brief    : Masked pattern match with level, run-length and one-shot modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module masked_match_detector #(
  parameter int W     = 2,
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [W-1:0]     cfg_mask,
  input  logic [RUN_W-1:0] cfg_run,
  input  logic [1:0]       cfg_mode,
  input  logic             rearm,
  input  logic             in_valid,
  input  logic [W-1:0]     x,
  output logic             f,
  output logic [CNT_W-1:0] hit_count,
  output logic [RUN_W-1:0] run_len,
  output logic             done
);

  localparam logic [1:0]       S_ARMED    = 2'd0;
  localparam logic [1:0]       S_COUNTING = 2'd1;
  localparam logic [1:0]       S_DONE     = 2'd2;
  localparam logic [1:0]       M_RUN      = 2'd1;
  localparam logic [1:0]       M_ONESHOT  = 2'd2;
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [RUN_W-1:0] c_RUN_MAX  = '1;

  logic [1:0]       r_state;
  logic [W-1:0]     r_pattern;
  logic [W-1:0]     r_mask;
  logic [RUN_W-1:0] r_run;
  logic [1:0]       r_mode;
  logic             r_f;
  logic [RUN_W-1:0] r_run_len;
  logic [CNT_W-1:0] r_hit;

  logic [1:0]       w_state_nxt;
  logic             w_f_nxt;
  logic [RUN_W-1:0] w_run_len_nxt;
  logic [CNT_W-1:0] w_hit_nxt;
  logic             w_match;
  logic [RUN_W-1:0] w_thr;
  logic [RUN_W-1:0] w_run_step;
  logic [CNT_W-1:0] w_hit_inc;

  assign w_match    = (((x ^ r_pattern) & r_mask) == '0);
  assign w_thr      = (r_run == '0) ? RUN_W'(1) : r_run;
  assign w_run_step = !w_match ? '0
                    : (r_run_len == c_RUN_MAX) ? r_run_len : r_run_len + RUN_W'(1);
  assign w_hit_inc  = (r_hit == c_CNT_MAX) ? r_hit : r_hit + CNT_W'(1);

  // State register, including configuration and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_ARMED;
      r_pattern <= '1;
      r_mask    <= '1;
      r_run     <= RUN_W'(1);
      r_mode    <= 2'd0;
      r_f       <= 1'b0;
      r_run_len <= '0;
      r_hit     <= '0;
    end else begin
      if (load) begin
        r_pattern <= cfg_pattern;
        r_mask    <= cfg_mask;
        r_run     <= cfg_run;
        r_mode    <= cfg_mode;
      end
      r_state   <= w_state_nxt;
      r_f       <= w_f_nxt;
      r_run_len <= w_run_len_nxt;
      r_hit     <= w_hit_nxt;
    end
  end

  // Next-state: load > rearm > sample
  always_comb begin
    w_state_nxt   = r_state;
    w_f_nxt       = r_f;
    w_run_len_nxt = r_run_len;
    w_hit_nxt     = r_hit;
    if (load) begin
      w_state_nxt   = S_ARMED;
      w_f_nxt       = 1'b0;
      w_run_len_nxt = '0;
      w_hit_nxt     = '0;
    end else if (r_state == S_DONE) begin
      w_f_nxt = 1'b0;
      if (rearm) begin
        w_run_len_nxt = '0;
        w_state_nxt   = S_ARMED;
      end
    end else if (in_valid) begin
      w_run_len_nxt = w_run_step;
      w_state_nxt   = (w_run_step == '0) ? S_ARMED : S_COUNTING;
      if (w_match) begin
        w_hit_nxt = w_hit_inc;
      end
      case (r_mode)
        M_RUN: w_f_nxt = (w_run_step >= w_thr);
        M_ONESHOT: begin
          w_f_nxt = (w_run_step >= w_thr);
          if (w_run_step >= w_thr) begin
            w_state_nxt = S_DONE;
          end
        end
        default: w_f_nxt = w_match;
      endcase
    end else if (r_mode == M_ONESHOT) begin
      w_f_nxt = 1'b0;
    end
  end

  always_comb begin
    f         = r_f;
    hit_count = r_hit;
    run_len   = r_run_len;
    done      = (r_state == S_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_masked_match_detector.sv
// ============================================================================
// Module   : tb_masked_match_detector
// Brief    : Directed self-checking bench for masked_match_detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_masked_match_detector;

  logic       clk = 1'b0;
  logic       reset, load, rearm, in_valid;
  logic [1:0] cfg_pattern, cfg_mask, cfg_mode, x;
  logic [3:0] cfg_run;
  logic       f, done, f2, done2;
  logic [7:0] hit_count;
  logic [1:0] hit2;
  logic [3:0] run_len, run2;

  int checks   = 0;
  int failures = 0;

  masked_match_detector #(.W(2), .CNT_W(8), .RUN_W(4)) dut (
    .clk(clk), .reset(reset), .load(load), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_run(cfg_run), .cfg_mode(cfg_mode), .rearm(rearm),
    .in_valid(in_valid), .x(x), .f(f), .hit_count(hit_count), .run_len(run_len),
    .done(done)
  );

  // Narrow-counter instance for hit_count saturation
  masked_match_detector #(.W(2), .CNT_W(2), .RUN_W(4)) dut2 (
    .clk(clk), .reset(reset), .load(load), .cfg_pattern(cfg_pattern),
    .cfg_mask(cfg_mask), .cfg_run(cfg_run), .cfg_mode(cfg_mode), .rearm(rearm),
    .in_valid(in_valid), .x(x), .f(f2), .hit_count(hit2), .run_len(run2),
    .done(done2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] p, input logic [1:0] m,
                         input logic [3:0] r, input logic [1:0] md);
    cfg_pattern = p; cfg_mask = m; cfg_run = r; cfg_mode = md;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic sample(input logic [1:0] v);
    x = v; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; x = 2'b11;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if ({f, done, run_len, hit_count} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs: got f=%b done=%b run=%0d hit=%0d, want all 0",
               f, done, run_len, hit_count);
    end
  endtask

  task automatic test_default_decode();
    logic [1:0] xs [4] = '{2'b11, 2'b10, 2'b11, 2'b01};
    logic       ef [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      sample(xs[i]);
      checks++;
      if (f !== ef[i]) begin
        failures++;
        $display("FAIL default_f[%0d]: got %b want %b", i, f, ef[i]);
      end
    end
    checks++;
    if (hit_count !== 8'd2) begin
      failures++;
      $display("FAIL default_hit: got %0d want 2", hit_count);
    end
  endtask

  task automatic test_masked_level();
    logic [1:0] xs [3] = '{2'b11, 2'b10, 2'b01};
    logic       ef [3] = '{1'b1, 1'b1, 1'b0};
    do_load(2'b10, 2'b10, 4'd1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      sample(xs[i]);
      checks++;
      if (f !== ef[i]) begin
        failures++;
        $display("FAIL masked_f[%0d]: got %b want %b", i, f, ef[i]);
      end
    end
    sample(2'b10);
    tick();
    checks++;
    if (f !== 1'b1) begin
      failures++;
      $display("FAIL level_hold_idle: got %b want 1", f);
    end
  endtask

  task automatic test_run();
    logic [1:0] xs [7] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       ef [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] er [7] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    do_load(2'b11, 2'b11, 4'd3, 2'd1);
    for (int i = 0; i < 7; i++) begin
      sample(xs[i]);
      checks++;
      if (f !== ef[i] || run_len !== er[i]) begin
        failures++;
        $display("FAIL run[%0d]: got f=%b run=%0d want f=%b run=%0d",
                 i, f, run_len, ef[i], er[i]);
      end
    end
    sample(2'b00);
    checks++;
    if (f !== 1'b0 || run_len !== 4'd0) begin
      failures++;
      $display("FAIL run_mismatch_drop: got f=%b run=%0d want f=0 run=0", f, run_len);
    end
  endtask

  task automatic test_oneshot();
    logic ef [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic ed [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    do_load(2'b11, 2'b11, 4'd2, 2'd2);
    for (int i = 0; i < 4; i++) begin
      sample(2'b11);
      checks++;
      if (f !== ef[i] || done !== ed[i]) begin
        failures++;
        $display("FAIL oneshot[%0d]: got f=%b done=%b want f=%b done=%b",
                 i, f, done, ef[i], ed[i]);
      end
    end
    checks++;
    if (hit_count !== 8'd2 || run_len !== 4'd2) begin
      failures++;
      $display("FAIL oneshot_frozen: got hit=%0d run=%0d want hit=2 run=2", hit_count, run_len);
    end
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    checks++;
    if (done !== 1'b0 || run_len !== 4'd0 || hit_count !== 8'd2) begin
      failures++;
      $display("FAIL rearm: got done=%b run=%0d hit=%0d want done=0 run=0 hit=2",
               done, run_len, hit_count);
    end
    sample(2'b11);
    checks++;
    if (f !== 1'b0) begin
      failures++;
      $display("FAIL rearm_first: got f=%b want 0", f);
    end
    sample(2'b11);
    checks++;
    if (f !== 1'b1 || done !== 1'b1 || hit_count !== 8'd4) begin
      failures++;
      $display("FAIL second_pulse: got f=%b done=%b hit=%0d want f=1 done=1 hit=4",
               f, done, hit_count);
    end
  endtask

  task automatic test_run_thresholds();
    do_load(2'b11, 2'b11, 4'd0, 2'd1);
    sample(2'b11);
    checks++;
    if (f !== 1'b1 || run_len !== 4'd1) begin
      failures++;
      $display("FAIL thr_zero: got f=%b run=%0d want f=1 run=1", f, run_len);
    end
    do_load(2'b11, 2'b11, 4'd15, 2'd1);
    for (int i = 0; i < 17; i++) begin
      sample(2'b11);
      checks++;
      if (f !== (i >= 14) || run_len !== ((i >= 14) ? 4'd15 : 4'(i + 1))) begin
        failures++;
        $display("FAIL run_sat[%0d]: got f=%b run=%0d want f=%b run=%0d", i, f,
                 run_len, (i >= 14), ((i >= 14) ? 4'd15 : 4'(i + 1)));
      end
    end
  endtask

  task automatic test_hit_saturate_and_load();
    do_load(2'b11, 2'b11, 4'd1, 2'd0);
    for (int i = 0; i < 6; i++) sample(2'b11);
    checks++;
    if (hit2 !== 2'd3 || hit_count !== 8'd6) begin
      failures++;
      $display("FAIL hit_sat: got hit2=%0d hit=%0d want hit2=3 hit=6", hit2, hit_count);
    end
    cfg_pattern = 2'b11; cfg_mask = 2'b11; cfg_run = 4'd1; cfg_mode = 2'd0;
    load = 1'b1; in_valid = 1'b1; x = 2'b11;
    tick();
    load = 1'b0; in_valid = 1'b0;
    checks++;
    if (hit_count !== 8'd0 || hit2 !== 2'd0 || run_len !== 4'd0 || f !== 1'b0) begin
      failures++;
      $display("FAIL load_with_sample: got hit=%0d hit2=%0d run=%0d f=%b want 0",
               hit_count, hit2, run_len, f);
    end
  endtask

  task automatic test_mid_reset();
    do_load(2'b01, 2'b01, 4'd3, 2'd1);
    sample(2'b11);
    sample(2'b01);
    checks++;
    if (run_len !== 4'd2 || f !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_run: got run=%0d f=%b want run=2 f=0", run_len, f);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({f, done, run_len, hit_count} !== 14'd0) begin
      failures++;
      $display("FAIL mid_reset: got f=%b done=%b run=%0d hit=%0d want all 0",
               f, done, run_len, hit_count);
    end
    sample(2'b11);
    checks++;
    if (f !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_level: got f=%b want 1", f);
    end
    sample(2'b01);
    checks++;
    if (f !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_pattern: got f=%b want 0", f);
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; rearm = 1'b0; in_valid = 1'b0; x = 2'b00;
    cfg_pattern = 2'b00; cfg_mask = 2'b00; cfg_run = 4'd0; cfg_mode = 2'd0;
    test_reset();
    test_default_decode();
    test_masked_level();
    test_run();
    test_oneshot();
    test_run_thresholds();
    test_hit_saturate_and_load();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
